ysyx_22050019_axi_rd_arbiter: RTL
=================================

YSYX_22050019_AXI_RD_ARBITER -- requirements
Module: ysyx_22050019_axi_rd_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 64, address width of all AR channels.
REQ-002 SHALL have parameter: DATA_W, 64, data width of all R channels.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have ports (master 0 = IFU): m0_arvalid in 1, m0_arready out 1, m0_araddr in ADDR_W, m0_rvalid out 1, m0_rready in 1, m0_rdata out DATA_W, m0_rresp out 2.
REQ-006 SHALL have ports (master 1 = LSU): m1_arvalid in 1, m1_arready out 1, m1_araddr in ADDR_W, m1_rvalid out 1, m1_rready in 1, m1_rdata out DATA_W, m1_rresp out 2.
REQ-007 SHALL have ports (shared slave): s_arvalid out 1, s_arready in 1, s_araddr out ADDR_W, s_rvalid in 1, s_rready out 1, s_rdata in DATA_W, s_rresp in 2.
REQ-008 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-009 SHALL sequence one single-beat read at a time with states IDLE, ADDR, DATA.
REQ-010 IDLE: SHALL arbitrate among masters whose arvalid is high; SHALL assert arready combinationally to the winner only; SHALL latch the winner's araddr and grant id on that edge; then go to ADDR.
REQ-011 IDLE with no arvalid: SHALL stay in IDLE, all arready low.
REQ-012 Fixed priority (default): SHALL grant master 1 over master 0 on simultaneous arvalid.
REQ-013 ADDR: SHALL drive s_arvalid=1 and s_araddr=latched address; all m*_arready=0; on s_arvalid&&s_arready go to DATA.
REQ-014 ADDR latency: s_arvalid SHALL first assert exactly one cycle after the master AR handshake.
REQ-015 DATA: SHALL route s_rvalid, s_rdata, s_rresp to the granted master only; s_rready SHALL equal granted master's rready; on s_rvalid&&s_rready go to IDLE.
REQ-016 The non-granted master SHALL see rvalid=0 and arready=0 for the whole transaction; its arvalid SHALL be held pending, not dropped.
REQ-017 m*_rdata/m*_rresp of a non-granted master SHALL be zero.
REQ-018 A new AR SHALL NOT be accepted in the same cycle as the R handshake; earliest next grant is the following IDLE cycle.
REQ-019 s_rresp values SHALL pass through unmodified; the arbiter SHALL NOT retry on error.
REQ-020 s_rvalid while in IDLE or ADDR SHALL be ignored (s_rready=0).

Reset
REQ-021 On rst_n=0 at a clock edge: state=IDLE, latched address=0, grant id=0, round-robin pointer=0.
REQ-022 During reset all outputs SHALL be 0: s_arvalid, s_rready, m*_arready, m*_rvalid, busy.
REQ-023 Reset mid-transaction SHALL abandon the outstanding read; no response is delivered to any master afterward.

Configuration
REQ-024 Macro YSYX_22050019_ARB_RR_EN defined: SHALL use round-robin; 1-bit pointer names the last granted master; on a tie the other master wins; pointer updates only on an IDLE grant.
REQ-025 Macro undefined: SHALL use the fixed priority of REQ-012 with no pointer register.

Structure
REQ-026 State encoding (IDLE=0, ADDR=1, DATA=2) and AXI RESP constants (OKAY=2'b00, SLVERR=2'b10) SHALL live in shared package ysyx_22050019_axi_pkg.
REQ-027 Grant selection SHALL be a sub-module ysyx_22050019_arb_sel (requests, pointer -> one-hot grant); the FSM and muxing stay top-level.

Verification
REQ-028 Single IFU read: m0 araddr=0x80000000, s_arready=1 one cycle after s_arvalid, s_rdata=0x00000013 with OKAY -> m0 gets rvalid with rdata=0x13; total 3 cycles minimum; m1 idle.
REQ-029 Simultaneous m0 0x80000004 and m1 0x80001000, fixed priority -> s_araddr=0x80001000 first, then 0x80000004; m0 arready held low until m1 R handshake completes.
REQ-030 RR_EN, both masters requesting continuously for 4 transactions -> grants alternate m1,m0,m1,m0 starting from pointer=0.
REQ-031 Backpressure: s_arready low 5 cycles, then m0_rready low 3 cycles while s_rvalid=1 -> s_araddr stable throughout, s_rready low until m0_rready rises; one handshake only.
REQ-032 rst_n=0 asserted in DATA state with s_rvalid=1 -> next cycle all outputs 0, state IDLE, no rvalid to either master.
REQ-033 s_rresp=SLVERR for m1 read at 0xA0000000 -> m1_rresp=2'b10 delivered once; arbiter back to IDLE.

Source files
------------

// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared types for the ysyx_22050019 AXI read arbiter: FSM states and
// AXI RESP codes.
package ysyx_22050019_axi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_22050019_arb_sel.sv
// Two-way grant selector: a lone request wins outright, and on a tie the
// master not named by the pointer wins.
module ysyx_22050019_arb_sel (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = i_req;
        if (&i_req) begin
            o_gnt = i_ptr ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/ysyx_22050019_axi_rd_arbiter.sv
// Two-master single-beat AXI read arbiter (IFU = m0, LSU = m1).
// Define YSYX_22050019_ARB_RR_EN for round-robin instead of LSU-first priority.
module ysyx_22050019_axi_rd_arbiter
    import ysyx_22050019_axi_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    output logic              busy
);

    state_e            r_state;
    state_e            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_gnt_id;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_ptr;
    logic              w_grant;
    logic              w_rready;

    assign w_req    = {m1_arvalid, m0_arvalid};
    assign w_grant  = (r_state == ST_IDLE) && (|w_req);
    assign w_rready = r_gnt_id ? m1_rready : m0_rready;

`ifdef YSYX_22050019_ARB_RR_EN
    logic r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_grant) begin
            r_ptr <= w_gnt[1];
        end
    end

    assign w_ptr = r_ptr;
`else
    // A pointer stuck at 0 makes the selector prefer master 1 on a tie.
    assign w_ptr = 1'b0;
`endif

    ysyx_22050019_arb_sel u_sel (
        .i_req (w_req),
        .i_ptr (w_ptr),
        .o_gnt (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_gnt_id <= 1'b0;
        end else if (w_grant) begin
            r_addr   <= w_gnt[1] ? m1_araddr : m0_araddr;
            r_gnt_id <= w_gnt[1];
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (|w_req) w_next = ST_ADDR;
            ST_ADDR: if (s_arready) w_next = ST_DATA;
            ST_DATA: if (s_rvalid && w_rready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Every control output is forced low while reset is held.
    always_comb begin
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        m0_rresp   = RESP_OKAY;
        m1_rresp   = RESP_OKAY;
        s_arvalid  = 1'b0;
        s_araddr   = r_addr;
        s_rready   = 1'b0;
        busy       = 1'b0;
        if (rst_n) begin
            busy = (r_state != ST_IDLE);
            unique case (r_state)
                ST_IDLE: begin
                    m0_arready = w_gnt[0];
                    m1_arready = w_gnt[1];
                end
                ST_ADDR: s_arvalid = 1'b1;
                ST_DATA: begin
                    s_rready = w_rready;
                    if (r_gnt_id) begin
                        m1_rvalid = s_rvalid;
                        m1_rdata  = s_rdata;
                        m1_rresp  = s_rresp;
                    end else begin
                        m0_rvalid = s_rvalid;
                        m0_rdata  = s_rdata;
                        m0_rresp  = s_rresp;
                    end
                end
                default: busy = 1'b0;
            endcase
        end
    end

endmodule
